// File: rtl/adder_share_arbiter.sv
// adder_share_arbiter
// Shares one combinational 3-input adder among NREQ requesters. A round-robin
// arbiter picks one requester, its operands are registered and presented to
// the adder for one cycle, and the captured sum is returned with the
// requester id on a result channel.
//
// Handshake semantics (both channels): a transfer happens on the rising edge
// where valid and ready are both high. A producer holds valid and its payload
// stable until the transfer; ready may depend combinationally on valid.
// req_ready is at most one-hot and is only ever high in IDLE; res_valid is
// high only in RESP and res_sum/res_id are held until the transfer.
module adder_share_arbiter #(
    parameter int NREQ = 4,
    parameter int DW   = 32,
    parameter int IDW  = 2
) (
    input  logic                ap_clk,
    input  logic                ap_rst_n,
    input  logic [NREQ-1:0]     req_valid,
    output logic [NREQ-1:0]     req_ready,
    input  logic [NREQ*DW-1:0]  req_in1,
    input  logic [NREQ*DW-1:0]  req_in2,
    input  logic [NREQ*DW-1:0]  req_in3,
    output logic [DW-1:0]       add_in1,
    output logic [DW-1:0]       add_in2,
    output logic [DW-1:0]       add_in3,
    input  logic [DW-1:0]       add_sum,
    output logic                res_valid,
    input  logic                res_ready,
    output logic [DW-1:0]       res_sum,
    output logic [IDW-1:0]      res_id,
    output logic [1:0]          dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t         state;
    logic [IDW-1:0] rr_ptr;
    logic [IDW-1:0] id_reg;
    logic [DW-1:0]  op1;
    logic [DW-1:0]  op2;
    logic [DW-1:0]  op3;

    logic           grant_any;
    logic [IDW-1:0] grant_id;
    logic [IDW-1:0] cand;

    // (base + off) mod NREQ, used for the search order and pointer advance
    function automatic logic [IDW-1:0] wrap_idx(input logic [IDW-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        return IDW'(s % NREQ);
    endfunction

    // Round-robin search: first valid requester starting at rr_ptr
    always_comb begin
        grant_any = 1'b0;
        grant_id  = '0;
        cand      = '0;
        for (int i = 0; i < NREQ; i++) begin
            cand = wrap_idx(rr_ptr, i);
            if (!grant_any && req_valid[cand]) begin
                grant_any = 1'b1;
                grant_id  = cand;
            end
        end
    end

    // One-hot accept in IDLE only; forced low while reset is asserted
    always_comb begin
        req_ready = '0;
        if (ap_rst_n && (state == IDLE) && grant_any) begin
            req_ready[grant_id] = 1'b1;
        end
    end

    // The adder always sees the registered operands, so its inputs only move on a grant edge
    assign add_in1   = op1;
    assign add_in2   = op2;
    assign add_in3   = op3;
    assign dbg_state = state;

    // Control FSM with registered operands and result
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            id_reg    <= '0;
            op1       <= '0;
            op2       <= '0;
            op3       <= '0;
            res_valid <= 1'b0;
            res_sum   <= '0;
            res_id    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_any) begin
                        op1    <= req_in1[int'(grant_id)*DW +: DW];
                        op2    <= req_in2[int'(grant_id)*DW +: DW];
                        op3    <= req_in3[int'(grant_id)*DW +: DW];
                        id_reg <= grant_id;
                        state  <= EXEC;
                    end
                end
                EXEC: begin
                    res_sum   <= add_sum;
                    res_id    <= id_reg;
                    res_valid <= 1'b1;
                    state     <= RESP;
                end
                RESP: begin
                    // Fairness pointer only moves once the result is taken
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        rr_ptr    <= wrap_idx(id_reg, 1);
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Directed bench for adder_share_arbiter with a behavioural shared adder.
module tb_adder_share_arbiter;

    localparam int NREQ = 4;
    localparam int DW   = 32;
    localparam int IDW  = 2;

    logic                ap_clk = 1'b0;
    logic                ap_rst_n;
    logic [NREQ-1:0]     req_valid;
    logic [NREQ-1:0]     req_ready;
    logic [NREQ*DW-1:0]  req_in1;
    logic [NREQ*DW-1:0]  req_in2;
    logic [NREQ*DW-1:0]  req_in3;
    logic [DW-1:0]       add_in1;
    logic [DW-1:0]       add_in2;
    logic [DW-1:0]       add_in3;
    logic [DW-1:0]       add_sum;
    logic                res_valid;
    logic                res_ready;
    logic [DW-1:0]       res_sum;
    logic [IDW-1:0]      res_id;
    logic [1:0]          dbg_state;

    int checks = 0;
    int errors = 0;

    logic [DW-1:0]  exp_q[$];
    logic [IDW-1:0] exp_id_q[$];

    adder_share_arbiter #(.NREQ(NREQ), .DW(DW), .IDW(IDW)) dut (
        .ap_clk    (ap_clk),
        .ap_rst_n  (ap_rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_in1   (req_in1),
        .req_in2   (req_in2),
        .req_in3   (req_in3),
        .add_in1   (add_in1),
        .add_in2   (add_in2),
        .add_in3   (add_in3),
        .add_sum   (add_sum),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_sum   (res_sum),
        .res_id    (res_id),
        .dbg_state (dbg_state)
    );

    // shared combinational adder
    assign add_sum = add_in1 + add_in2 + add_in3;

    // clock
    always #5 ap_clk = ~ap_clk;

    // watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge ap_clk);
        #1;
    endtask

    task automatic set_ops(input int k, input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [DW-1:0] c);
        req_in1[k*DW +: DW] = a;
        req_in2[k*DW +: DW] = b;
        req_in3[k*DW +: DW] = c;
    endtask

    task automatic test_reset();
        ap_rst_n  = 1'b0;
        req_valid = '0;
        res_ready = 1'b1;
        req_in1   = '0;
        req_in2   = '0;
        req_in3   = '0;
        tick();
        tick();
        checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL reset_res_valid: got %b want 0", res_valid); end
        checks++; if (res_sum !== '0) begin errors++; $display("FAIL reset_res_sum: got %h want 0", res_sum); end
        checks++; if (res_id !== '0) begin errors++; $display("FAIL reset_res_id: got %0d want 0", res_id); end
        checks++; if (req_ready !== '0) begin errors++; $display("FAIL reset_req_ready: got %b want 0000", req_ready); end
        checks++; if ({add_in1, add_in2, add_in3} !== '0) begin errors++; $display("FAIL reset_add_in: got %h/%h/%h want 0/0/0", add_in1, add_in2, add_in3); end
        checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", dbg_state); end
        ap_rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single();
        set_ops(2, 32'd5, 32'd7, 32'd9);
        req_valid = 4'b0100;
        #1;
        checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL single_grant: got %b want 0100", req_ready); end
        tick();
        req_valid = '0;
        #1;
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL single_exec_ready: got %b want 0000", req_ready); end
        checks++; if ({add_in1, add_in2, add_in3} !== {32'd5, 32'd7, 32'd9}) begin errors++; $display("FAIL single_add_in: got %0d/%0d/%0d want 5/7/9", add_in1, add_in2, add_in3); end
        checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL single_early_valid: got %b want 0", res_valid); end
        checks++; if (dbg_state !== 2'd1) begin errors++; $display("FAIL single_exec_state: got %0d want 1", dbg_state); end
        tick();
        checks++; if (res_valid !== 1'b1) begin errors++; $display("FAIL single_res_valid: got %b want 1", res_valid); end
        checks++; if (res_sum !== 32'd21) begin errors++; $display("FAIL single_res_sum: got %0d want 21", res_sum); end
        checks++; if (res_id !== 2'd2) begin errors++; $display("FAIL single_res_id: got %0d want 2", res_id); end
        tick();
        checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL single_res_drop: got %b want 0", res_valid); end
        checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL single_idle_state: got %0d want 0", dbg_state); end
    endtask

    task automatic test_wrap();
        set_ops(0, 32'hFFFF_FFFF, 32'd1, 32'd2);
        req_valid = 4'b0001;
        #1;
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL wrap_grant: got %b want 0001", req_ready); end
        tick();
        req_valid = '0;
        tick();
        checks++; if (res_valid !== 1'b1) begin errors++; $display("FAIL wrap_res_valid: got %b want 1", res_valid); end
        checks++; if (res_sum !== 32'h0000_0002) begin errors++; $display("FAIL wrap_res_sum: got %h want 00000002", res_sum); end
        checks++; if (res_id !== 2'd0) begin errors++; $display("FAIL wrap_res_id: got %0d want 0", res_id); end
        tick();
    endtask

    // rr_ptr is 1 here: requesters 0 and 3 pending gives 3 then 0
    task automatic test_skip();
        set_ops(3, 32'd3, 32'd4, 32'd5);
        set_ops(0, 32'd100, 32'd200, 32'd300);
        req_valid = 4'b1001;
        #1;
        checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL skip_first_grant: got %b want 1000", req_ready); end
        tick();
        #1;
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL skip_exec_ready: got %b want 0000", req_ready); end
        tick();
        checks++; if ({res_valid, res_id, res_sum} !== {1'b1, 2'd3, 32'd12}) begin errors++; $display("FAIL skip_first_res: got v=%b id=%0d sum=%0d want v=1 id=3 sum=12", res_valid, res_id, res_sum); end
        tick();
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL skip_second_grant: got %b want 0001", req_ready); end
        tick();
        req_valid = '0;
        tick();
        checks++; if ({res_valid, res_id, res_sum} !== {1'b1, 2'd0, 32'd600}) begin errors++; $display("FAIL skip_second_res: got v=%b id=%0d sum=%0d want v=1 id=0 sum=600", res_valid, res_id, res_sum); end
        tick();
    endtask

    // rr_ptr is 1 here; requester 2 is granted, then reset lands in EXEC
    task automatic test_reset_mid();
        set_ops(2, 32'd11, 32'd22, 32'd33);
        set_ops(1, 32'd10, 32'd20, 32'd30);
        req_valid = 4'b0100;
        #1;
        checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL rmid_grant: got %b want 0100", req_ready); end
        tick();
        req_valid = 4'b0110;
        #1;
        checks++; if (dbg_state !== 2'd1) begin errors++; $display("FAIL rmid_in_exec: got %0d want 1", dbg_state); end
        ap_rst_n = 1'b0;
        #1;
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL rmid_req_ready: got %b want 0000", req_ready); end
        checks++; if ({add_in1, add_in2, add_in3} !== '0) begin errors++; $display("FAIL rmid_add_in: got %h/%h/%h want 0/0/0", add_in1, add_in2, add_in3); end
        checks++; if ({res_valid, res_id, res_sum} !== '0) begin errors++; $display("FAIL rmid_res: got v=%b id=%0d sum=%0d want all 0", res_valid, res_id, res_sum); end
        checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL rmid_state: got %0d want 0", dbg_state); end
        tick();
        ap_rst_n = 1'b1;
        #1;
        checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL rmid_post_grant: got %b want 0010", req_ready); end
        tick();
        req_valid = '0;
        tick();
        checks++; if ({res_valid, res_id, res_sum} !== {1'b1, 2'd1, 32'd60}) begin errors++; $display("FAIL rmid_post_res: got v=%b id=%0d sum=%0d want v=1 id=1 sum=60", res_valid, res_id, res_sum); end
        tick();
        checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL rmid_no_extra: got %b want 0", res_valid); end
    endtask

    task automatic test_round_robin();
        int order[5];
        int n_grant;
        int n_res;
        int last;
        logic [DW-1:0]  e_sum;
        logic [IDW-1:0] e_id;
        order   = '{0, 1, 2, 3, 0};
        n_grant = 0;
        n_res   = 0;
        last    = 0;
        ap_rst_n = 1'b0;
        tick();
        ap_rst_n = 1'b1;
        for (int k = 0; k < NREQ; k++) begin
            set_ops(k, DW'(k + 1), DW'(10 * (k + 1)), DW'(100 * (k + 1)));
        end
        res_ready = 1'b1;
        req_valid = 4'b1111;
        for (int cyc = 0; cyc < 40 && (n_grant < 5 || n_res < 5); cyc++) begin
            #1;
            if (req_ready !== 4'b0000) begin
                checks++;
                if (n_grant >= 5) begin
                    errors++; $display("FAIL rr_extra_grant: got %b want 0000", req_ready);
                end else if (req_ready !== (4'b0001 << order[n_grant])) begin
                    errors++; $display("FAIL rr_grant_%0d: got %b want %b", n_grant, req_ready, 4'b0001 << order[n_grant]);
                end
                if (n_grant > 0 && n_grant < 5) begin
                    checks++;
                    if (cyc - last != 3) begin errors++; $display("FAIL rr_spacing_%0d: got %0d want 3", n_grant, cyc - last); end
                end
                if (n_grant < 5) begin
                    exp_id_q.push_back(IDW'(order[n_grant]));
                    exp_q.push_back(DW'(111 * (order[n_grant] + 1)));
                end
                last = cyc;
                n_grant++;
            end
            if (res_valid && res_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++; $display("FAIL rr_unexpected_res: got id=%0d sum=%0d want none", res_id, res_sum);
                end else begin
                    e_sum = exp_q.pop_front();
                    e_id  = exp_id_q.pop_front();
                    if (res_id !== e_id || res_sum !== e_sum) begin
                        errors++; $display("FAIL rr_res_%0d: got id=%0d sum=%0d want id=%0d sum=%0d", n_res, res_id, res_sum, e_id, e_sum);
                    end
                end
                n_res++;
            end
            tick();
            if (n_grant >= 5) req_valid = '0;
        end
        req_valid = '0;
        checks++;
        if (n_grant != 5 || n_res != 5) begin errors++; $display("FAIL rr_count: got grants=%0d results=%0d want 5/5", n_grant, n_res); end
    endtask

    // rr_ptr is 1 here
    task automatic test_backpressure();
        set_ops(1, 32'd10, 32'd20, 32'd30);
        set_ops(2, 32'd1, 32'd2, 32'd3);
        res_ready = 1'b0;
        req_valid = 4'b0010;
        #1;
        checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL bp_grant: got %b want 0010", req_ready); end
        tick();
        req_valid = 4'b0100;
        tick();
        checks++; if ({res_valid, res_id, res_sum} !== {1'b1, 2'd1, 32'd60}) begin errors++; $display("FAIL bp_res: got v=%b id=%0d sum=%0d want v=1 id=1 sum=60", res_valid, res_id, res_sum); end
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if ({res_valid, res_id, res_sum, req_ready} !== {1'b1, 2'd1, 32'd60, 4'b0000}) begin
                errors++; $display("FAIL bp_hold_%0d: got v=%b id=%0d sum=%0d ready=%b want v=1 id=1 sum=60 ready=0000", i, res_valid, res_id, res_sum, req_ready);
            end
        end
        res_ready = 1'b1;
        tick();
        checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL bp_release: got %b want 0", res_valid); end
        checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL bp_resume_grant: got %b want 0100", req_ready); end
        tick();
        req_valid = '0;
        tick();
        checks++; if ({res_valid, res_id, res_sum} !== {1'b1, 2'd2, 32'd6}) begin errors++; $display("FAIL bp_second_res: got v=%b id=%0d sum=%0d want v=1 id=2 sum=6", res_valid, res_id, res_sum); end
        tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_wrap();
        test_skip();
        test_reset_mid();
        test_round_robin();
        test_backpressure();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
